pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage write-enables and flush (bubble) controls.
- Handles load-use stalls, branch/jump redirect squashes and variable-latency data-memory waits, with a timeout.
- Sits beside the pipeline registers and drives their enable/flush inputs.
- Keeps a saturating stall-cycle counter.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_TIMEOUT, 16, max cycles waiting for dmem_ack before error (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
id_rs  in  REG_ADDR_W  source reg 1 of instruction in ID
id_rt  in  REG_ADDR_W  source reg 2 of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  MemRead of instruction in EX
ex_rt  in  REG_ADDR_W  load destination of instruction in EX
mem_branch  in  1  Branch flag in MEM
mem_zero  in  1  ALU zero flag in MEM
mem_jump  in  1  Jump flag in MEM
mem_access  in  1  MemRead|MemWrite of instruction in MEM
dmem_ack  in  1  data memory completes access this cycle
pc_we  out  1  PC load enable
pc_redirect  out  1  PC mux selects branch/jump target (PC_next_MEM)
ifid_we, idex_we, exmem_we  out  1 each  stage register enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all control bits 0)
mem_err  out  1  sticky memory-timeout error
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Registered state: fsm (RUN, MEM_WAIT, HALT), wait counter, mem_err, stall_count. Control outputs are combinational from state and inputs, same-cycle.
- Reset (rst_n=0 at edge): fsm=RUN, wait counter=0, mem_err=0, stall_count=0.
  - While rst_n=0, outputs are forced: all *_we=0, all *_flush=1, pc_redirect=0.
- Default (no event): all *_we=1, all flush=0, pc_redirect=0.
- RUN priority, highest first:
  1. Memory wait: mem_access=1 and dmem_ack=0.
     - pc_we=ifid_we=idex_we=exmem_we=0, memwb_flush=1.
     - Next MEM_WAIT, wait counter=1.
  2. Redirect: mem_access=0 and ((mem_branch & mem_zero) | mem_jump).
     - pc_redirect=1, pc_we=1, ifid_flush=idex_flush=exmem_flush=1.
     - Stay RUN.
  3. Load-use: ex_memread=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
     - pc_we=0, ifid_we=0, idex_flush=1; other stages advance.
     - Exactly one bubble; the hazard is not re-detected next cycle.
  - mem_access=1 with dmem_ack=1: single-cycle access, no stall.
- MEM_WAIT:
  - Freeze as in (1) every cycle.
  - dmem_ack=1: default outputs that cycle, next RUN, counter cleared.
  - Else counter+1. If counter==MEM_TIMEOUT with no ack: mem_err<=1, next HALT.
  - Redirect and load-use are ignored while in MEM_WAIT.
- HALT: all *_we=0, all flush=0. Only reset exits.
- stall_count: +1 on every cycle with any stage frozen or a load-use bubble (RUN cases 1 and 3, all MEM_WAIT cycles, HALT). Saturates at all-ones. Redirect cycles are not counted.
- Load-use with ex_rt==0 never stalls.

Decomposition:
- Shared package pipe_pkg holds:
  - fsm state enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2)
  - REG_ADDR_W default
  - typedef of the stage-control bundle {we, flush}
- One natural sub-module: hazard_detect, the combinational load-use comparator producing load_use.

Test Plan:
- Reset held 3 cycles then released, no events -> during reset all we=0, flush=1; after release all we=1, flush=0, stall_count=0.
- ex_memread=1, ex_rt=5, id_rs=5 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle only; stall_count=1. Repeat with ex_rt=0 -> no stall.
- mem_branch=1, mem_zero=1 -> pc_redirect=1, ifid/idex/exmem_flush=1 same cycle; mem_branch=1, mem_zero=0 -> no flush.
- mem_access=1, dmem_ack rises after 3 cycles -> 3 frozen cycles with memwb_flush=1, advance on the ack cycle; stall_count=3. A simultaneous load-use condition is ignored until RUN.
- mem_access=1, dmem_ack never asserted, MEM_TIMEOUT=16 -> mem_err=1 after 16 wait cycles, fsm HALT, all we=0 until rst_n=0.
- Force stall_count near saturation (CNT_W=4, 20 stall cycles) -> stall_count holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// per-stage {we, flush} control bundle.
package pipe_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } fsm_t;

   typedef struct packed {
      logic we;
      logic flush;
   } stage_ctl_t;

   localparam stage_ctl_t STAGE_ADV    = '{we: 1'b1, flush: 1'b0};
   localparam stage_ctl_t STAGE_HOLD   = '{we: 1'b0, flush: 1'b0};
   localparam stage_ctl_t STAGE_BUBBLE = '{we: 1'b1, flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX targets a register the ID instruction reads.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   output logic                  load_use
);

   // A load into r0 produces nothing to wait for.
   assign load_use = ex_memread && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes for load-use
// stalls, branch/jump squashes and variable-latency data-memory waits.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  mem_branch,
   input  logic                  mem_zero,
   input  logic                  mem_jump,
   input  logic                  mem_access,
   input  logic                  dmem_ack,
   output logic                  pc_we,
   output logic                  pc_redirect,
   output logic                  ifid_we,
   output logic                  idex_we,
   output logic                  exmem_we,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic                  memwb_flush,
   output logic                  mem_err,
   output logic [CNT_W-1:0]      stall_count
);

   localparam int               WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   fsm_t              state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              lu_blk_q, lu_blk_d;

   logic       load_use;
   logic       redirect;
   logic       mem_stall;
   logic       stall_cyc;
   logic       pc_we_c, pc_redirect_c, memwb_flush_c;
   stage_ctl_t ifid_c, idex_c, exmem_c;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .load_use   (load_use)
   );

   assign redirect  = (mem_branch && mem_zero) || mem_jump;
   assign mem_stall = mem_access && !dmem_ack;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      mem_err_d     = mem_err_q;
      lu_blk_d      = 1'b0;
      stall_cyc     = 1'b0;
      pc_we_c       = 1'b1;
      pc_redirect_c = 1'b0;
      ifid_c        = STAGE_ADV;
      idex_c        = STAGE_ADV;
      exmem_c       = STAGE_ADV;
      memwb_flush_c = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               pc_we_c       = 1'b0;
               ifid_c        = STAGE_HOLD;
               idex_c        = STAGE_HOLD;
               exmem_c       = STAGE_HOLD;
               memwb_flush_c = 1'b1;
               stall_cyc     = 1'b1;
               wait_d        = WAIT_W'(1);
               state_d       = MEM_WAIT;
            end else if (!mem_access && redirect) begin
               pc_redirect_c = 1'b1;
               ifid_c        = STAGE_BUBBLE;
               idex_c        = STAGE_BUBBLE;
               exmem_c       = STAGE_BUBBLE;
            end else if (load_use && !lu_blk_q) begin
               // One bubble only: the stalled instruction must not re-trigger next cycle.
               pc_we_c   = 1'b0;
               ifid_c    = STAGE_HOLD;
               idex_c    = STAGE_BUBBLE;
               lu_blk_d  = 1'b1;
               stall_cyc = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack) begin
               wait_d  = '0;
               state_d = RUN;
            end else begin
               pc_we_c       = 1'b0;
               ifid_c        = STAGE_HOLD;
               idex_c        = STAGE_HOLD;
               exmem_c       = STAGE_HOLD;
               memwb_flush_c = 1'b1;
               stall_cyc     = 1'b1;
               wait_d        = wait_q + 1'b1;
               if (wait_d == TIMEOUT_V) begin
                  mem_err_d = 1'b1;
                  state_d   = HALT;
               end
            end
         end
         HALT: begin
            pc_we_c   = 1'b0;
            ifid_c    = STAGE_HOLD;
            idex_c    = STAGE_HOLD;
            exmem_c   = STAGE_HOLD;
            stall_cyc = 1'b1;
         end
         default: state_d = RUN;
      endcase

      // Everything is squashed while reset is held.
      if (!rst_n) begin
         pc_we_c       = 1'b0;
         pc_redirect_c = 1'b0;
         ifid_c        = '{we: 1'b0, flush: 1'b1};
         idex_c        = '{we: 1'b0, flush: 1'b1};
         exmem_c       = '{we: 1'b0, flush: 1'b1};
         memwb_flush_c = 1'b1;
      end

      stall_d = stall_q;
      if (stall_cyc && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
         lu_blk_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         stall_q   <= stall_d;
         lu_blk_q  <= lu_blk_d;
      end
   end

   assign pc_we       = pc_we_c;
   assign pc_redirect = pc_redirect_c;
   assign ifid_we     = ifid_c.we;
   assign idex_we     = idex_c.we;
   assign exmem_we    = exmem_c.we;
   assign ifid_flush  = ifid_c.flush;
   assign idex_flush  = idex_c.flush;
   assign exmem_flush = exmem_c.flush;
   assign memwb_flush = memwb_flush_c;
   assign mem_err     = mem_err_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_memread;
   logic       mem_branch, mem_zero, mem_jump, mem_access, dmem_ack;

   logic        pc_we, pc_redirect, ifid_we, idex_we, exmem_we;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err;
   logic [15:0] stall_count;

   logic        pc_we4, pc_redirect4, ifid_we4, idex_we4, exmem_we4;
   logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, mem_err4;
   logic [3:0]  stall_count4;

   int vectors     = 0;
   int miscompares = 0;

   // {pc_we, pc_redirect, ifid_we, idex_we, exmem_we, ifid/idex/exmem/memwb_flush}
   localparam logic [8:0] C_RST = 9'b0_0_000_1111;
   localparam logic [8:0] C_DEF = 9'b1_0_111_0000;
   localparam logic [8:0] C_LU  = 9'b0_0_011_0100;
   localparam logic [8:0] C_RED = 9'b1_1_111_1110;
   localparam logic [8:0] C_FRZ = 9'b0_0_000_0001;
   localparam logic [8:0] C_HLT = 9'b0_0_000_0000;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_jump(mem_jump), .mem_access(mem_access), .dmem_ack(dmem_ack),
      .pc_we(pc_we), .pc_redirect(pc_redirect), .ifid_we(ifid_we), .idex_we(idex_we),
      .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mem_err(mem_err),
      .stall_count(stall_count)
   );

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_jump(mem_jump), .mem_access(mem_access), .dmem_ack(dmem_ack),
      .pc_we(pc_we4), .pc_redirect(pc_redirect4), .ifid_we(ifid_we4), .idex_we(idex_we4),
      .exmem_we(exmem_we4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
      .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4), .mem_err(mem_err4),
      .stall_count(stall_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [8:0] exp);
      chk(tag, {23'd0, pc_we, pc_redirect, ifid_we, idex_we, exmem_we,
                ifid_flush, idex_flush, exmem_flush, memwb_flush}, {23'd0, exp});
      chk({tag, "_w4"}, {23'd0, pc_we4, pc_redirect4, ifid_we4, idex_we4, exmem_we4,
                ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4}, {23'd0, exp});
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0;
      mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
      mem_access = 1'b0; dmem_ack = 1'b0;
   endtask

   // Advance to just after the next rising edge, where new inputs are applied.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();

      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         next();
         #1 chk_ctl("reset_ctl", C_RST);
      end
      next(); rst_n = 1'b1;
      #1 chk_ctl("post_reset_ctl", C_DEF);
      chk("post_reset_stall", 32'(stall_count), 32'd0);
      chk("post_reset_err", {31'd0, mem_err}, 32'd0);

      // Load-use via rs, held two cycles: only one bubble
      next(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #1 chk_ctl("lu_rs", C_LU);
      next();
      #1 chk_ctl("lu_rs_no_redetect", C_DEF);
      next(); idle();
      #1 chk("lu_rs_stall", 32'(stall_count), 32'd1);

      // Load-use via rt
      ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
      #1 chk_ctl("lu_rt", C_LU);
      next(); idle();
      #1 chk_ctl("after_lu_rt", C_DEF);
      chk("lu_rt_stall", 32'(stall_count), 32'd2);

      // rt match but ID does not read rt
      next(); ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
      #1 chk_ctl("rt_unused", C_DEF);
      // Load into r0 never stalls
      next(); idle(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1 chk_ctl("lu_r0", C_DEF);

      // Branch taken / not taken / jump
      next(); idle(); mem_branch = 1'b1; mem_zero = 1'b1;
      #1 chk_ctl("br_taken", C_RED);
      next(); mem_zero = 1'b0;
      #1 chk_ctl("br_not_taken", C_DEF);
      next(); idle(); mem_jump = 1'b1; ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      #1 chk_ctl("jump_over_lu", C_RED);
      next(); idle();
      #1 chk("redirect_stall", 32'(stall_count), 32'd2);

      // Memory wait, ack on fourth cycle, load-use held throughout
      mem_access = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #1 chk_ctl("mw_enter", C_FRZ);
      next();
      #1 chk_ctl("mw_wait1", C_FRZ);
      next();
      #1 chk_ctl("mw_wait2", C_FRZ);
      next(); dmem_ack = 1'b1;
      #1 chk_ctl("mw_ack", C_DEF);
      chk("mw_stall", 32'(stall_count), 32'd5);
      next(); mem_access = 1'b0; dmem_ack = 1'b0;
      #1 chk_ctl("lu_after_mw", C_LU);
      next(); idle();
      #1 chk("lu_after_mw_stall", 32'(stall_count), 32'd6);
      chk("lu_after_mw_stall4", 32'(stall_count4), 32'd6);

      // Single-cycle access: no stall, and redirect needs mem_access=0
      mem_access = 1'b1; dmem_ack = 1'b1; mem_jump = 1'b1;
      #1 chk_ctl("mem_1cyc", C_DEF);

      // Timeout: 16 frozen cycles without ack, then HALT
      next(); idle(); mem_access = 1'b1;
      #1 chk_ctl("to_enter", C_FRZ);
      for (int i = 1; i <= 15; i++) begin
         next();
         #1 chk_ctl("to_wait", C_FRZ);
         chk("to_err_low", {31'd0, mem_err}, 32'd0);
      end
      next();
      #1 chk_ctl("to_halt", C_HLT);
      chk("to_err", {31'd0, mem_err}, 32'd1);
      chk("to_err4", {31'd0, mem_err4}, 32'd1);
      chk("to_stall", 32'(stall_count), 32'd22);
      for (int i = 0; i < 4; i++) begin
         next(); idle(); dmem_ack = 1'b1; mem_jump = 1'b1;
         #1 chk_ctl("halt_hold", C_HLT);
      end
      chk("halt_stall", 32'(stall_count), 32'd26);
      chk("sat_stall4", 32'(stall_count4), 32'd15);

      // Reset exits HALT
      next(); idle(); rst_n = 1'b0;
      #1 chk_ctl("rst_again", C_RST);
      next(); rst_n = 1'b1;
      #1 chk_ctl("rst_again_run", C_DEF);
      chk("rst_again_err", {31'd0, mem_err}, 32'd0);
      chk("rst_again_stall", 32'(stall_count), 32'd0);
      chk("rst_again_stall4", 32'(stall_count4), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
